radar_chirp_core: RTL and testbench



---
 rtl/radar_chirp_core.sv | 317 +++++++++++++++++++++++++++++++
 tb/tb_radar_chirp_core.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/radar_chirp_core.sv
// -----------------------------------------------------------------------------
// radar_chirp_core
//   Pulsed-radar timing and datapath core. A PRF timer fires a one-cycle tick;
//   each tick (when idle) launches a transmit pulse on `tx`, either a linear-FM
//   chirp from a phase accumulator or a waveform replayed from a buffer that is
//   loaded over the tx_t* stream. The same tick starts a capture of a
//   programmable number of `rx` samples, emitted as one rx_t* packet carrying a
//   128-bit CVITA-style header on rx_tuser.
//
// Ports
//   clk, resetn          : clock, asynchronous active-low reset
//   set_stb/addr/data    : settings-bus write (SR_BASE+0..6)
//   rb_addr / rb_data    : register readback (see RADAR_READBACK_EN)
//   vita_time            : timestamp, latched on the first captured sample
//   src_sid / dst_sid    : stream IDs placed in the rx header
//   tx                   : DAC sample {I[31:16], Q[15:0]}, zero while idle
//   rx                   : ADC sample
//   tx_tdata/tlast/tvalid/tready : waveform load stream (always ready)
//   rx_tdata/tuser/tlast/tvalid/tready : captured-sample stream (no backpressure)
//
// Configuration macro
//   RADAR_READBACK_EN : when defined, rb_data is a registered readback mux;
//                       otherwise rb_data is tied to zero.
// -----------------------------------------------------------------------------
module radar_chirp_core #(
  parameter int          SR_BASE  = 64,
  parameter int          AWG_AW   = 8,
  parameter logic [31:0] WFRM_CMD = 32'h57574441
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          set_stb,
  input  logic [7:0]    set_addr,
  input  logic [31:0]   set_data,
  input  logic [7:0]    rb_addr,
  output logic [63:0]   rb_data,
  input  logic [63:0]   vita_time,
  input  logic [15:0]   src_sid,
  input  logic [15:0]   dst_sid,
  output logic [31:0]   tx,
  input  logic [31:0]   rx,
  input  logic [31:0]   tx_tdata,
  input  logic          tx_tlast,
  input  logic          tx_tvalid,
  output logic          tx_tready,
  output logic [31:0]   rx_tdata,
  output logic [127:0]  rx_tuser,
  output logic          rx_tlast,
  output logic          rx_tvalid,
  input  logic          rx_tready
);

  localparam logic [7:0] A_CH_COUNTER  = 8'(SR_BASE + 0);
  localparam logic [7:0] A_TUNING_COEF = 8'(SR_BASE + 1);
  localparam logic [7:0] A_FREQ_OFFSET = 8'(SR_BASE + 2);
  localparam logic [7:0] A_CTRL_WORD   = 8'(SR_BASE + 3);
  localparam logic [7:0] A_PRF_INT     = 8'(SR_BASE + 4);
  localparam logic [7:0] A_PRF_FRAC    = 8'(SR_BASE + 5);
  localparam logic [7:0] A_ADC_SAMPLE  = 8'(SR_BASE + 6);
  localparam int         AWG_DEPTH     = 1 << AWG_AW;

  typedef enum logic {ST_IDLE, ST_PULSE} state_t;

  // Triangle wave from the top 16 phase bits, returned as a signed sample
  // (offset-binary value with the MSB flipped).
  function automatic logic [15:0] f_triangle(input logic [15:0] p);
    logic [15:0] t;
    t = p[15] ? ~{p[14:0], 1'b0} : {p[14:0], 1'b0};
    return t ^ 16'h8000;
  endfunction

  // ---------------------------------------------------------------- settings
  logic [31:0] r_ch_counter, r_tuning_coef, r_freq_offset, r_ctrl_word;
  logic [31:0] r_prf_int, r_prf_frac, r_adc_sample;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_ch_counter  <= '0;
      r_tuning_coef <= '0;
      r_freq_offset <= '0;
      r_ctrl_word   <= '0;
      r_prf_int     <= '0;
      r_prf_frac    <= 32'h0000_03FF;
      r_adc_sample  <= '0;
    end else if (set_stb) begin
      case (set_addr)
        A_CH_COUNTER:  r_ch_counter  <= set_data;
        A_TUNING_COEF: r_tuning_coef <= set_data;
        A_FREQ_OFFSET: r_freq_offset <= set_data;
        A_CTRL_WORD:   r_ctrl_word   <= set_data;
        A_PRF_INT:     r_prf_int     <= set_data;
        A_PRF_FRAC:    r_prf_frac    <= set_data;
        A_ADC_SAMPLE:  r_adc_sample  <= set_data;
        default: ;
      endcase
    end
  end

  logic w_run, w_awg_sel;
  assign w_run     = r_ctrl_word[4];
  assign w_awg_sel = (r_ctrl_word[9:8] == 2'b11);

  // --------------------------------------------------------------- PRF timer
  logic [31:0] r_prf_cnt;
  logic [31:0] w_prf_term;
  logic        w_tick;

  assign w_prf_term = {r_prf_int[15:0], r_prf_frac[15:0]};
  assign w_tick     = w_run && (r_prf_cnt == w_prf_term);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)              r_prf_cnt <= '0;
    else if (!w_run || w_tick) r_prf_cnt <= '0;
    else                      r_prf_cnt <= r_prf_cnt + 32'd1;
  end

  // ------------------------------------------------------------ waveform load
  logic [31:0]     r_awg_mem [AWG_DEPTH];
  logic [31:0]     r_awg_rd;
  logic [2:0]      r_hdr_cnt;
  logic            r_drop;
  logic [AWG_AW:0] r_wr_cnt;
  logic [AWG_AW:0] r_awg_len;
  logic            w_drop_now, w_wr_en;
  logic [AWG_AW:0] w_wr_cnt_next;

  assign tx_tready     = 1'b1;
  // The command word is judged on beat 0 itself, so a bad packet that ends on
  // its first beat is already recognised as bad at tlast.
  assign w_drop_now    = (r_hdr_cnt == 3'd0) ? (tx_tdata != WFRM_CMD) : r_drop;
  // The MSB of the write count marks a full buffer; further samples are dropped.
  assign w_wr_en       = tx_tvalid && (r_hdr_cnt == 3'd5) && !r_drop && !r_wr_cnt[AWG_AW];
  assign w_wr_cnt_next = w_wr_en ? r_wr_cnt + (AWG_AW + 1)'(1) : r_wr_cnt;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_hdr_cnt <= '0;
      r_drop    <= 1'b0;
      r_wr_cnt  <= '0;
      r_awg_len <= '0;
    end else if (tx_tvalid) begin
      if (tx_tlast) begin
        r_hdr_cnt <= '0;
        r_drop    <= 1'b0;
        r_wr_cnt  <= '0;
        if (!w_drop_now) r_awg_len <= w_wr_cnt_next;
      end else begin
        if (r_hdr_cnt != 3'd5) r_hdr_cnt <= r_hdr_cnt + 3'd1;
        r_drop   <= w_drop_now;
        r_wr_cnt <= w_wr_cnt_next;
      end
    end
  end

  // ------------------------------------------------------------ pulse FSM
  state_t        r_state, w_state_next;
  logic          w_pulse_start;
  logic [20:0]   r_remain;
  logic [20:0]   w_pulse_len;
  logic          r_act_awg;
  logic [31:0]   r_act_tune, r_phase, r_inc;
  logic [31:0]   r_tx_chirp, w_chirp_word;
  logic [15:0]   w_chirp_p;
  logic [AWG_AW-1:0] r_awg_ptr, w_awg_raddr;

  assign w_pulse_len = w_awg_sel ? 21'(r_awg_len)
                                 : ({1'b0, r_ch_counter[15:0], 4'b0000} + 21'd16);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= ST_IDLE;
    else         r_state <= w_state_next;
  end

  always_comb begin
    w_state_next  = r_state;
    w_pulse_start = 1'b0;
    case (r_state)
      ST_IDLE: begin
        // An empty waveform buffer suppresses the AWG pulse entirely.
        if (w_tick && !(w_awg_sel && (r_awg_len == '0))) begin
          w_state_next  = ST_PULSE;
          w_pulse_start = 1'b1;
        end
      end
      ST_PULSE: begin
        if (r_remain == '0) w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Sample 0 always uses phase 0; later samples use the accumulated phase.
  assign w_chirp_p    = w_pulse_start ? 16'h0000 : r_phase[31:16];
  assign w_chirp_word = {f_triangle(w_chirp_p), f_triangle(w_chirp_p + 16'h4000)};

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_remain   <= '0;
      r_act_awg  <= 1'b0;
      r_act_tune <= '0;
      r_phase    <= '0;
      r_inc      <= '0;
      r_tx_chirp <= '0;
      r_awg_ptr  <= '0;
    end else if (w_pulse_start) begin
      r_remain   <= w_pulse_len - 21'd1;
      r_act_awg  <= w_awg_sel;
      r_act_tune <= r_tuning_coef;
      r_phase    <= r_freq_offset;
      r_inc      <= r_freq_offset + r_tuning_coef;
      r_tx_chirp <= w_chirp_word;
      r_awg_ptr  <= AWG_AW'(1);
    end else if ((r_state == ST_PULSE) && (r_remain != '0)) begin
      r_remain   <= r_remain - 21'd1;
      r_phase    <= r_phase + r_inc;
      r_inc      <= r_inc + r_act_tune;
      r_tx_chirp <= w_chirp_word;
      r_awg_ptr  <= r_awg_ptr + AWG_AW'(1);
    end
  end

  // While idle the buffer continuously reads address 0, so the registered read
  // already holds sample 0 on the first pulse cycle; the pointer then runs one
  // address ahead of the sample being shown.
  assign w_awg_raddr = (r_state == ST_PULSE) ? r_awg_ptr : '0;

  always_ff @(posedge clk) begin
    if (w_wr_en) r_awg_mem[r_wr_cnt[AWG_AW-1:0]] <= tx_tdata;
    r_awg_rd <= r_awg_mem[w_awg_raddr];
  end

  assign tx = (r_state == ST_PULSE) ? (r_act_awg ? r_awg_rd : r_tx_chirp) : 32'h0;

  // ------------------------------------------------------------ capture
  logic          r_cap_active;
  logic [15:0]   r_cap_cnt, r_cap_last_idx;
  logic [11:0]   r_seqnum;
  logic          r_overflow;
  logic [31:0]   r_rx_tdata;
  logic [127:0]  r_rx_tuser;
  logic          r_rx_tvalid, r_rx_tlast;
  logic [15:0]   w_byte_len;

  // 4*(N+1)+16 bytes = 4*N + 20
  assign w_byte_len = {r_cap_last_idx[13:0], 2'b00} + 16'd20;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_cap_active   <= 1'b0;
      r_cap_cnt      <= '0;
      r_cap_last_idx <= '0;
      r_seqnum       <= '0;
      r_overflow     <= 1'b0;
      r_rx_tdata     <= '0;
      r_rx_tuser     <= '0;
      r_rx_tvalid    <= 1'b0;
      r_rx_tlast     <= 1'b0;
    end else begin
      r_rx_tvalid <= r_cap_active;
      r_rx_tlast  <= r_cap_active && (r_cap_cnt == r_cap_last_idx);
      if (r_cap_active) r_rx_tdata <= rx;
      if (r_cap_active && (r_cap_cnt == 16'd0))
        r_rx_tuser <= {2'b00, 1'b1, 1'b1, r_seqnum, w_byte_len, src_sid, dst_sid, vita_time};

      if (w_tick && !r_cap_active) begin
        r_cap_active   <= 1'b1;
        r_cap_cnt      <= '0;
        r_cap_last_idx <= r_adc_sample[15:0];
      end else if (r_cap_active) begin
        if (r_cap_cnt == r_cap_last_idx) begin
          r_cap_active <= 1'b0;
          r_seqnum     <= r_seqnum + 12'd1;
        end else begin
          r_cap_cnt <= r_cap_cnt + 16'd1;
        end
      end

      // A beat offered while the consumer is not ready is lost for good.
      if (r_rx_tvalid && !rx_tready) r_overflow <= 1'b1;
    end
  end

  assign rx_tdata  = r_rx_tdata;
  assign rx_tuser  = r_rx_tuser;
  assign rx_tvalid = r_rx_tvalid;
  assign rx_tlast  = r_rx_tlast;

  // ------------------------------------------------------------ readback
`ifdef RADAR_READBACK_EN
  logic [63:0] r_rb_data;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_rb_data <= '0;
    end else begin
      case (rb_addr)
        8'd0:    r_rb_data <= {r_ctrl_word, r_prf_frac};
        8'd1:    r_rb_data <= {{(31 - AWG_AW){1'b0}}, r_awg_len, 19'b0, r_overflow, r_seqnum};
        8'd2:    r_rb_data <= {r_ch_counter, r_adc_sample};
        default: r_rb_data <= '0;
      endcase
    end
  end

  assign rb_data = r_rb_data;
`else
  assign rb_data = 64'h0;
`endif

  // Register bits that only matter for readback (or not at all).
  logic w_unused;
  assign w_unused = &{1'b0, rb_addr, r_prf_int[31:16], r_prf_frac[31:16],
                      r_ch_counter[31:16], r_adc_sample[31:16],
                      r_ctrl_word[31:10], r_ctrl_word[7:5], r_ctrl_word[3:0],
                      r_overflow};

endmodule

// File: tb/tb_radar_chirp_core.sv
module tb_radar_chirp_core;

  localparam int P = 512;                      // PRF period with PRF_FRAC=0x1FF
  localparam logic [15:0] SRC = 16'h1234;
  localparam logic [15:0] DST = 16'hABCD;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          set_stb = 1'b0;
  logic [7:0]    set_addr = 8'h0;
  logic [31:0]   set_data = 32'h0;
  logic [7:0]    rb_addr = 8'h0;
  logic [63:0]   rb_data;
  logic [63:0]   vita_time = 64'h0;
  logic [15:0]   src_sid = SRC;
  logic [15:0]   dst_sid = DST;
  logic [31:0]   tx;
  logic [31:0]   rx = 32'h0;
  logic [31:0]   tx_tdata = 32'h0;
  logic          tx_tlast = 1'b0;
  logic          tx_tvalid = 1'b0;
  logic          tx_tready;
  logic [31:0]   rx_tdata;
  logic [127:0]  rx_tuser;
  logic          rx_tlast;
  logic          rx_tvalid;
  logic          rx_tready = 1'b1;

  radar_chirp_core dut (
    .clk(clk), .resetn(resetn),
    .set_stb(set_stb), .set_addr(set_addr), .set_data(set_data),
    .rb_addr(rb_addr), .rb_data(rb_data),
    .vita_time(vita_time), .src_sid(src_sid), .dst_sid(dst_sid),
    .tx(tx), .rx(rx),
    .tx_tdata(tx_tdata), .tx_tlast(tx_tlast), .tx_tvalid(tx_tvalid), .tx_tready(tx_tready),
    .rx_tdata(rx_tdata), .rx_tuser(rx_tuser), .rx_tlast(rx_tlast),
    .rx_tvalid(rx_tvalid), .rx_tready(rx_tready)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int dropped = 0;
  logic [11:0] exp_seq = 12'd0;

  // Cycle n is the interval after the n-th rising edge.
  logic [31:0] cyc = 32'd0;
  always @(posedge clk) cyc <= cyc + 32'd1;

  // rx carries the cycle number (or tx from 8 cycles earlier in loopback),
  // vita_time carries the cycle number.
  logic        loop_mode = 1'b0;
  logic [31:0] hist [16];
  always @(negedge clk) hist[cyc[3:0]] = tx;
  always @(posedge clk) begin
    #1;
    vita_time = {32'h0, cyc};
    rx = loop_mode ? hist[4'(cyc - 32'd8)] : cyc;
  end

  // ------------------------------------------------------------ scoreboard
  typedef struct packed {
    logic [31:0]  data;
    logic         last;
    logic [127:0] user;
  } beat_t;

  beat_t sb[$];
  beat_t mon_e;

  always @(negedge clk) begin
    if (resetn && rx_tvalid) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_beat: got data=%h last=%b, required no beat", rx_tdata, rx_tlast);
      end else begin
        mon_e = sb.pop_front();
        if (rx_tready) begin
          total++;
          if (rx_tdata !== mon_e.data || rx_tlast !== mon_e.last || rx_tuser !== mon_e.user) begin
            bad++;
            $display("FAIL rx_beat: got data=%h last=%b user=%h, required data=%h last=%b user=%h",
                     rx_tdata, rx_tlast, rx_tuser, mon_e.data, mon_e.last, mon_e.user);
          end else begin
            $display("rx beat data=%h last=%b seq=%0d", rx_tdata, rx_tlast, rx_tuser[123:112]);
          end
        end else begin
          dropped++;
          $display("rx beat data=%h dropped (tready=0)", rx_tdata);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  // ------------------------------------------------------------ models
  function automatic logic [15:0] tri16(input logic [15:0] p);
    logic [15:0] r;
    if (p[15]) r = ~{p[14:0], 1'b0};
    else       r = {p[14:0], 1'b0};
    return r - 16'h8000;
  endfunction

  function automatic logic [31:0] chirp_model(input int k, input logic [31:0] f, input logic [31:0] t);
    logic [31:0] ph;
    logic [31:0] inc;
    ph = 32'h0;
    inc = f;
    for (int i = 0; i < k; i++) begin
      ph = ph + inc;
      inc = inc + t;
    end
    return {tri16(ph[31:16]), tri16(ph[31:16] + 16'h4000)};
  endfunction

  function automatic logic [127:0] hdr_model(input logic [11:0] seq, input int n, input logic [31:0] t0);
    logic [15:0] len;
    len = 16'(4 * n + 16);
    return {2'b00, 1'b1, 1'b1, seq, len, SRC, DST, 32'h0, t0};
  endfunction

  // ------------------------------------------------------------ stimulus helpers
  task automatic set_reg(input int off, input logic [31:0] d, output logic [31:0] c);
    @(negedge clk);
    c = cyc;
    set_stb = 1'b1;
    set_addr = 8'(64 + off);
    set_data = d;
    @(negedge clk);
    set_stb = 1'b0;
  endtask

  task automatic wait_cycle(input logic [31:0] n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
    #1;
  endtask

  // Expected packet when rx carries the cycle number; s = first sample cycle.
  task automatic push_packet(input logic [31:0] s, input int n);
    beat_t b;
    for (int j = 0; j < n; j++) begin
      b.data = s + 32'(j);
      b.last = (j == n - 1);
      b.user = hdr_model(exp_seq, n, s);
      sb.push_back(b);
    end
    exp_seq = exp_seq + 12'd1;
  endtask

  task automatic wait_drain(input int budget, output bit ok);
    for (int i = 0; i < budget && sb.size() != 0; i++) @(negedge clk);
    ok = (sb.size() == 0);
    sb.delete();
  endtask

  // ------------------------------------------------------------ tests
  task automatic test_reset();
    resetn = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    total++; if (tx !== 32'h0) begin bad++; $display("FAIL reset_tx: got %h, required 0", tx); end
    total++; if (rx_tvalid !== 1'b0) begin bad++; $display("FAIL reset_rx_tvalid: got %b, required 0", rx_tvalid); end
    total++; if (rx_tlast !== 1'b0) begin bad++; $display("FAIL reset_rx_tlast: got %b, required 0", rx_tlast); end
    total++; if (rx_tdata !== 32'h0) begin bad++; $display("FAIL reset_rx_tdata: got %h, required 0", rx_tdata); end
    total++; if (rx_tuser !== 128'h0) begin bad++; $display("FAIL reset_rx_tuser: got %h, required 0", rx_tuser); end
    total++; if (tx_tready !== 1'b1) begin bad++; $display("FAIL reset_tx_tready: got %b, required 1", tx_tready); end
    total++; if (rb_data !== 64'h0) begin bad++; $display("FAIL reset_rb_data: got %h, required 0", rb_data); end
    resetn = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      total++;
      if (tx !== 32'h0 || rx_tvalid !== 1'b0) begin
        bad++;
        $display("FAIL idle_after_reset: got tx=%h rx_tvalid=%b, required tx=0 rx_tvalid=0", tx, rx_tvalid);
      end
    end
    $display("reset: outputs checked, 100 idle cycles");
  endtask

  task automatic test_prf_capture();
    logic [31:0] c;
    bit ok;
    set_reg(6, 32'h0000_000F, c);
    set_reg(0, 32'h0000_0001, c);
    set_reg(5, 32'h0000_01FF, c);
    set_reg(2, 32'h0100_0000, c);
    set_reg(1, 32'h0000_0000, c);
    set_reg(3, 32'h0000_0010, c);
    for (int m = 0; m < 3; m++) push_packet(c + 32'(P + 1 + m * P), 16);
    wait_drain(3 * P + 200, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL prf_capture_drain: got missing beats, required 3 packets of 16"); end
    set_reg(3, 32'h0, c);
    $display("prf_capture: 3 packets scheduled from cycle %0d", c);
  endtask

  task automatic test_chirp();
    logic [31:0] c;
    logic [31:0] s;
    logic [31:0] e;
    bit ok;
    set_reg(3, 32'h0000_0010, c);
    for (int m = 0; m < 2; m++) push_packet(c + 32'(P + 1 + m * P), 16);
    for (int p = 0; p < 2; p++) begin
      s = c + 32'(P + 1 + p * P);
      wait_cycle(s - 32'd1);
      total++;
      if (tx !== 32'h0) begin bad++; $display("FAIL chirp_pre_pulse: got %h, required 0", tx); end
      for (int k = 0; k < 32; k++) begin
        wait_cycle(s + 32'(k));
        e = chirp_model(k, 32'h0100_0000, 32'h0);
        total++;
        if (tx !== e) begin bad++; $display("FAIL chirp_sample%0d: got %h, required %h", k, tx, e); end
      end
      wait_cycle(s + 32'd32);
      total++;
      if (tx !== 32'h0) begin bad++; $display("FAIL chirp_post_pulse: got %h, required 0", tx); end
      $display("chirp: pulse %0d at cycle %0d, 32 samples", p, s);
    end
    wait_drain(P, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL chirp_drain: got missing beats, required 2 packets"); end
    set_reg(3, 32'h0, c);
  endtask

  task automatic play_awg(input string tag);
    logic [31:0] c;
    logic [31:0] s;
    bit ok;
    set_reg(3, 32'h0000_0310, c);
    push_packet(c + 32'(P + 1), 16);
    s = c + 32'(P + 1);
    for (int k = 0; k < 251; k++) begin
      wait_cycle(s + 32'(k));
      total++;
      if (tx !== 32'(k + 5)) begin bad++; $display("FAIL %s_sample%0d: got %h, required %h", tag, k, tx, 32'(k + 5)); end
    end
    wait_cycle(s + 32'd251);
    total++;
    if (tx !== 32'h0) begin bad++; $display("FAIL %s_len: got tx=%h after 251 samples, required 0", tag, tx); end
    wait_drain(P, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL %s_drain: got missing beats, required 1 packet", tag); end
    set_reg(3, 32'h0, c);
    $display("%s: 251-sample waveform pulse at cycle %0d", tag, s);
  endtask

  task automatic test_awg();
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      tx_tvalid = 1'b1;
      tx_tlast = (i == 255);
      case (i)
        0: tx_tdata = 32'h5757_4441;
        1: tx_tdata = 32'h0000_0007;
        2: tx_tdata = 32'h0000_0000;
        3: tx_tdata = 32'd1004;
        4: tx_tdata = 32'h0;
        default: tx_tdata = 32'(i);
      endcase
      total++;
      if (tx_tready !== 1'b1) begin bad++; $display("FAIL awg_tready_beat%0d: got %b, required 1", i, tx_tready); end
    end
    @(negedge clk);
    tx_tvalid = 1'b0;
    tx_tlast = 1'b0;
    $display("awg: loaded 256-beat waveform packet");
`ifdef RADAR_READBACK_EN
    rb_addr = 8'd1;
    @(negedge clk);
    @(negedge clk);
    total++;
    if (rb_data[63:32] !== 32'd251) begin bad++; $display("FAIL awg_len_rb: got %0d, required 251", rb_data[63:32]); end
`endif
    play_awg("awg");
  endtask

  task automatic test_bad_header();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      tx_tvalid = 1'b1;
      tx_tlast = (i == 19);
      tx_tdata = (i == 0) ? 32'hDEAD_BEEF : (32'hBAD0_0000 + 32'(i));
    end
    @(negedge clk);
    tx_tvalid = 1'b0;
    tx_tlast = 1'b0;
    $display("bad_header: sent 20-beat packet with cmd DEADBEEF");
    play_awg("bad_header");
  endtask

  task automatic test_loopback();
    logic [31:0] c;
    logic [31:0] s;
    beat_t b;
    bit ok;
    loop_mode = 1'b1;
    repeat (20) @(negedge clk);
    dropped = 0;
    set_reg(1, 32'h0010_0000, c);
    set_reg(3, 32'h0000_0010, c);
    s = c + 32'(P + 1);
    for (int j = 0; j < 16; j++) begin
      b.data = (j < 8) ? 32'h0 : chirp_model(j - 8, 32'h0100_0000, 32'h0010_0000);
      b.last = (j == 15);
      b.user = hdr_model(exp_seq, 16, s);
      sb.push_back(b);
    end
    exp_seq = exp_seq + 12'd1;
    wait_cycle(s + 32'd4);
    rx_tready = 1'b0;
    wait_cycle(s + 32'd5);
    rx_tready = 1'b1;
    wait_drain(P, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL loopback_drain: got missing beats, required 1 packet"); end
    total++;
    if (dropped !== 1) begin bad++; $display("FAIL loopback_dropped: got %0d, required 1", dropped); end
`ifdef RADAR_READBACK_EN
    rb_addr = 8'd1;
    @(negedge clk);
    @(negedge clk);
    total++;
    if (rb_data[12] !== 1'b1) begin bad++; $display("FAIL overflow_rb: got %b, required 1", rb_data[12]); end
`else
    total++;
    if (rb_data !== 64'h0) begin bad++; $display("FAIL rb_tied: got %h, required 0", rb_data); end
`endif
    set_reg(3, 32'h0, c);
    loop_mode = 1'b0;
    $display("loopback: packet at cycle %0d, dropped=%0d", s, dropped);
  endtask

  initial begin
    test_reset();
    test_prf_capture();
    test_chirp();
    test_awg();
    test_bad_header();
    test_loopback();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
